uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, SHALL set clocks per serial bit; legal range 2..63.
REQ-002 Parameter DATA_BITS, default 8, SHALL set payload bits per frame; legal range 5..8.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 byte_in  input  DATA_BITS  SHALL carry the byte to transmit, sampled only on acceptance.
REQ-006 valid_in  input  1  SHALL indicate byte_in holds a byte to transmit.
REQ-007 ready_out  output  1  SHALL indicate a byte can be accepted this cycle.
REQ-008 bit_out  output  1  SHALL be the serial line; idle level is 1.
REQ-009 done_out  output  1  SHALL pulse high for one cycle when a frame's stop bit completes.

Function
REQ-010 The block SHALL use states IDLE, START, DATA, PARITY (present only with the macro) and STOP.
REQ-011 Acceptance SHALL occur on a cycle with valid_in=1 and ready_out=1; byte_in SHALL then be latched.
REQ-012 ready_out SHALL be 1 in IDLE and in the final cycle of STOP, and 0 otherwise.
REQ-013 valid_in while ready_out=0 SHALL be ignored, with no queuing.
REQ-014 Changes on byte_in after acceptance SHALL NOT affect the frame in progress.
REQ-015 bit_out SHALL go 0 (start bit) on the cycle after acceptance, i.e. latency 1 clock.
REQ-016 Each of start, data, parity and stop bits SHALL be held on bit_out for exactly CLKS_PER_BIT cycles.
REQ-017 Data bits SHALL be sent LSB first, then the stop bit as 1.
REQ-018 Without parity, a frame SHALL last (DATA_BITS+2)*CLKS_PER_BIT cycles.
REQ-019 Acceptance in the final STOP cycle SHALL start the next start bit on the following cycle with no idle gap.
REQ-020 Without acceptance in the final STOP cycle, the block SHALL return to IDLE with bit_out=1.
REQ-021 done_out SHALL assert in the final STOP cycle, whether or not a new byte is accepted.
REQ-022 The bit-period counter and bit index counter SHALL wrap to 0 at each bit/frame boundary, and SHALL never exceed CLKS_PER_BIT-1 or DATA_BITS-1.

Reset
REQ-023 On reset: state=IDLE, bit_out=1, ready_out=1, done_out=0, all counters=0, latched byte=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; bit_out SHALL be 1 from the following cycle.
REQ-025 Reset SHALL take priority over a simultaneous acceptance.

Configuration
REQ-026 With UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and send an even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles.
REQ-027 With UART_TX_PARITY_EN defined, the frame length SHALL be (DATA_BITS+3)*CLKS_PER_BIT cycles.
REQ-028 Without UART_TX_PARITY_EN, no parity logic or state SHALL exist.

Structure
REQ-029 Package uart_pkg SHALL hold the tx state enum typedef, the idle-line constant (1) and default CLKS_PER_BIT/DATA_BITS constants.
REQ-030 Sub-module shift_reg_par_in_serial_out (parallel load, shift-right enable, LSB on serial output) SHALL hold the latched byte.

Verification
REQ-031 Send 0x55 with CLKS_PER_BIT=4 -> bit_out shows 0,1,0,1,0,1,0,1,0,1, 4 cycles each; done_out fires 40 cycles after the start bit begins.
REQ-032 Loop bit_out into the team's UART receiver and send 0xA5, then 0x3C -> the receiver outputs 0xA5 then 0x3C with its ready_out pulse.
REQ-033 Hold valid_in=1 with 0x0F then 0xF0 -> the second start bit immediately follows the first stop bit, with no idle cycle and exactly 80 cycles total.
REQ-034 Assert reset at cycle 17 of a 0xFF frame -> bit_out=1 and ready_out=1 next cycle, and no done_out pulse.
REQ-035 Pulse valid_in with 0x00 during DATA -> the pulse is ignored, and the current frame and bit_out are unchanged.
REQ-036 With UART_TX_PARITY_EN, send 0x07 -> parity bit is 1 and the frame is 44 cycles; send 0x03 -> parity bit is 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART transmitter shared types and constants
// UART_TX_PARITY_EN adds the PARITY state to the tx state enum.
package uart_pkg;

  localparam logic IDLE_LINE            = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 4;
  localparam int   DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/shift_reg_par_in_serial_out.sv
// rtl/shift_reg_par_in_serial_out.sv - parallel-load, shift-right register with LSB serial output
module shift_reg_par_in_serial_out #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] data_q;

  // load wins over shift so a back-to-back frame is never corrupted
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= data_in;
    end else if (shift) begin
      data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
  end

  assign serial_out = data_q[0];

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter, start/data/stop framing, LSB first
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] byte_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 bit_out,
  output logic                 done_out
);

  localparam logic [5:0] CNT_LAST = 6'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_t  state, state_next;
  logic [5:0] clk_cnt, clk_cnt_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic       load, shift, accept, bit_end, data_bit;

  assign bit_end   = (clk_cnt == CNT_LAST);
  assign done_out  = (state == TX_STOP) && bit_end;
  assign ready_out = (state == TX_IDLE) || done_out;
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_idx <= bit_idx_next;
    end
  end

  shift_reg_par_in_serial_out #(
    .WIDTH (DATA_BITS)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .shift      (shift),
    .data_in    (byte_in),
    .serial_out (data_bit)
  );

`ifdef UART_TX_PARITY_EN
  // parity is captured at load because the shifter consumes the byte
  logic parity_bit;
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (load) begin
      parity_bit <= ^byte_in;
    end
  end
`endif

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    load         = 1'b0;
    shift        = 1'b0;
    case (state)
      TX_IDLE: begin
        if (accept) begin
          state_next   = TX_START;
          clk_cnt_next = '0;
          bit_idx_next = '0;
          load         = 1'b1;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_next   = TX_DATA;
          clk_cnt_next = '0;
          bit_idx_next = '0;
        end else begin
          clk_cnt_next = clk_cnt + 6'd1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift        = 1'b1;
          clk_cnt_next = '0;
          if (bit_idx == IDX_LAST) begin
            bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = TX_PARITY;
`else
            state_next   = TX_STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 6'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          state_next   = TX_STOP;
          clk_cnt_next = '0;
        end else begin
          clk_cnt_next = clk_cnt + 6'd1;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          if (accept) begin
            state_next = TX_START;
            load       = 1'b1;
          end else begin
            state_next = TX_IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + 6'd1;
        end
      end
      default: begin
        state_next   = TX_IDLE;
        clk_cnt_next = '0;
        bit_idx_next = '0;
      end
    endcase
  end

  always_comb begin
    bit_out = IDLE_LINE;
    case (state)
      TX_START:  bit_out = ~IDLE_LINE;
      TX_DATA:   bit_out = data_bit;
`ifdef UART_TX_PARITY_EN
      TX_PARITY: bit_out = parity_bit;
`endif
      default:   bit_out = IDLE_LINE;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter against a frame-queue model
module tb_uart_transmitter;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_BITS = DB + 2 + PAR;
  localparam int FL         = FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DB-1:0] byte_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out, bit_out, done_out;

  uart_transmitter #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .byte_in   (byte_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .bit_out   (bit_out),
    .done_out  (done_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one queue entry per future clock cycle of line level and done flag
  typedef struct packed {
    logic line;
    logic done;
  } slot_t;

  slot_t         exp_q[$];
  logic [DB-1:0] acc_q[$];

  function automatic logic m_ready();
    return exp_q.size() <= 1;
  endfunction

  task automatic push_frame(input logic [DB-1:0] b);
    logic  lvl;
    slot_t s;
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (k == 0)                    lvl = 1'b0;
      else if (k <= DB)              lvl = b[k-1];
      else if (PAR == 1 && k == DB+1) lvl = ^b;
      else                           lvl = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        s.line = lvl;
        s.done = (k == FRAME_BITS - 1) && (c == CPB - 1);
        exp_q.push_back(s);
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      logic acc;
      acc = valid_in && m_ready();
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        push_frame(byte_in);
        acc_q.push_back(byte_in);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      logic el, ed;
      el = (exp_q.size() > 0) ? exp_q[0].line : 1'b1;
      ed = (exp_q.size() > 0) ? exp_q[0].done : 1'b0;
      check("line", bit_out, el);
      check("done", done_out, ed);
      check("ready", ready_out, m_ready());
    end
  end

  // Independent serial decoder: samples mid-bit and checks bytes against accepted order
  logic          rx_busy = 1'b0;
  logic          prev_line = 1'b1;
  int            rx_cnt = 0;
  logic [DB-1:0] rx_byte = '0;

  always @(negedge clk) begin
    if (!checking || reset) begin
      rx_busy   = 1'b0;
      prev_line = 1'b1;
    end else begin
      if (!rx_busy) begin
        if (prev_line && !bit_out) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_busy && (rx_cnt % CPB) == CPB / 2) begin
        int idx;
        idx = rx_cnt / CPB;
        if (idx == 0) begin
          check("rx_start", bit_out, 0);
        end else if (idx <= DB) begin
          rx_byte[idx-1] = bit_out;
        end else if (PAR == 1 && idx == DB + 1) begin
          check("rx_parity", bit_out, ^rx_byte);
        end else begin
          check("rx_stop", bit_out, 1);
          if (acc_q.size() == 0) check("rx_unexpected_frame", 0, 1);
          else check("rx_byte", rx_byte, acc_q.pop_front());
          rx_busy = 1'b0;
        end
      end
      prev_line = bit_out;
    end
  end

  logic line_rec  [0:199];
  logic done_rec  [0:199];
  logic ready_rec [0:199];

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      line_rec[i]  = bit_out;
      done_rec[i]  = done_out;
      ready_rec[i] = ready_out;
    end
  endtask

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (done_rec[i]) n++;
    return n;
  endfunction

  function automatic int count_low(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (!line_rec[i]) n++;
    return n;
  endfunction

  function automatic int first_done(input int hi);
    for (int i = 0; i <= hi; i++) if (done_rec[i]) return i;
    return -1;
  endfunction

  task automatic send_one(input logic [DB-1:0] b);
    @(posedge clk); #1;
    byte_in  = b;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    byte_in  = DB'($urandom);
  endtask

  initial begin
    logic [15:0]   pat;
    logic [3:0]    grp;
    logic [DB-1:0] word;

    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    check("reset_line", bit_out, 1);
    check("reset_ready", ready_out, 1);
    check("reset_done", done_out, 0);

    // random traffic with occasional resets, including reset coinciding with valid
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(posedge clk); #1;
      r        = $urandom_range(0, 199);
      reset    = (r < 2);
      valid_in = (r < 70);
      byte_in  = DB'($urandom);
    end
    @(posedge clk); #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    repeat (2 * FL) @(posedge clk);
    #1;
    check("drained", acc_q.size(), 0);

    // 0x55 frame, literal waveform
`ifdef UART_TX_PARITY_EN
    pat = 16'h04AA;
`else
    pat = 16'h02AA;
`endif
    send_one(8'h55);
    record(FL + 5);
    for (int k = 0; k < FRAME_BITS; k++) begin
      grp = {line_rec[k*CPB+3], line_rec[k*CPB+2], line_rec[k*CPB+1], line_rec[k*CPB]};
      check("t1_bit_level", grp, pat[k] ? 4'hF : 4'h0);
    end
    check("t1_done_index", first_done(FL + 4), (PAR == 1) ? 43 : 39);
    check("t1_done_count", count_done(0, FL + 4), 1);
    check("t1_idle_after", count_low(FL, FL + 4), 0);

    // back-to-back 0x0F then 0xF0 with valid held high
    repeat (4) @(posedge clk);
    #1;
    byte_in  = 8'h0F;
    valid_in = 1'b1;
    @(posedge clk); #1;
    byte_in  = 8'hF0;
    for (int i = 0; i < 2 * FL + 5; i++) begin
      @(negedge clk);
      line_rec[i] = bit_out;
      done_rec[i] = done_out;
      if (i == FL) valid_in = 1'b0;
    end
    check("t2_first_done", done_rec[FL-1], 1);
    check("t2_stop_level", line_rec[FL-1], 1);
    check("t2_no_gap_start", line_rec[FL], 0);
    check("t2_second_done_index", 2 * FL - 1 - 0, (PAR == 1) ? 87 : 79);
    check("t2_second_done", done_rec[2*FL-1], 1);
    check("t2_done_count", count_done(0, 2 * FL + 4), 2);
    check("t2_f1_bit0", line_rec[CPB+1], 1);
    check("t2_f1_bit4", line_rec[5*CPB+1], 0);
    check("t2_f2_bit0", line_rec[FL+CPB+1], 0);
    check("t2_f2_bit4", line_rec[FL+5*CPB+1], 1);
    check("t2_idle_after", line_rec[2*FL], 1);

    // reset during cycle 17 of a 0xFF frame
    repeat (4) @(posedge clk);
    send_one(8'hFF);
    repeat (17) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("t3_busy_before_reset", ready_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t3_line_after_reset", bit_out, 1);
    check("t3_ready_after_reset", ready_out, 1);
    check("t3_done_after_reset", done_out, 0);
    record(FL);
    check("t3_no_done", count_done(0, FL - 1), 0);
    check("t3_line_idle", count_low(0, FL - 1), 0);

    // valid pulse with 0x00 during DATA is ignored
    send_one(8'h96);
    for (int i = 0; i < FL + 10; i++) begin
      @(negedge clk);
      line_rec[i]  = bit_out;
      done_rec[i]  = done_out;
      ready_rec[i] = ready_out;
      if (i == 9) begin
        byte_in  = 8'h00;
        valid_in = 1'b1;
      end
      if (i == 10) valid_in = 1'b0;
    end
    for (int k = 0; k < DB; k++) word[k] = line_rec[CPB*(k+1)+1];
    check("t4_ready_in_data", ready_rec[9], 0);
    check("t4_data", word, 8'h96);
    check("t4_done_index", first_done(FL + 9), FL - 1);
    check("t4_done_count", count_done(0, FL + 9), 1);
    check("t4_no_second_frame", count_low(FL, FL + 9), 0);

`ifdef UART_TX_PARITY_EN
    send_one(8'h07);
    record(FL + 4);
    check("t5_parity_07", line_rec[(DB+1)*CPB+1], 1);
    check("t5_frame_len", first_done(FL + 3) + 1, 44);
    send_one(8'h03);
    record(FL + 4);
    check("t5_parity_03", line_rec[(DB+1)*CPB+1], 0);
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
